// File: rtl/spdif_rate_scan_ctrl.sv
// S/PDIF half-bit period scanner: sweeps the receiver's period until it
// reports lock, qualifies lock with a run of sample acks, then classifies rate.
module spdif_rate_scan_ctrl #(
    parameter int MIN_CLK_PER_HALFBIT      = 4,
    parameter int MAX_CLK_PER_HALFBIT      = 31,
    parameter int MAX_CLK_PER_HALFBIT_LOG2 = 5,
    parameter int SETTLE_CYCLES            = 4096,
    parameter int QUALIFY_ACKS             = 16,
    parameter int TH_192K                  = 5,
    parameter int TH_96K                   = 10,
    parameter int TH_48K                   = 20
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                dai_locked_i,
    input  logic                                dai_ack_i,
    input  logic                                hold_i,
    output logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] clk_per_halfbit_o,
    output logic                                locked_o,
    output logic                                rst_o,
    output logic [3:0]                          rate_o,
    output logic                                scanning_o
);

    localparam int PW = MAX_CLK_PER_HALFBIT_LOG2;
    localparam int TW = $clog2(SETTLE_CYCLES + 1);
    localparam int AW = $clog2(QUALIFY_ACKS + 1);

    localparam logic [PW-1:0] P_MIN  = PW'(MIN_CLK_PER_HALFBIT);
    localparam logic [PW-1:0] P_MAX  = PW'(MAX_CLK_PER_HALFBIT);
    localparam logic [PW-1:0] T_192  = PW'(TH_192K);
    localparam logic [PW-1:0] T_96   = PW'(TH_96K);
    localparam logic [PW-1:0] T_48   = PW'(TH_48K);
    localparam logic [TW-1:0] T_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [AW-1:0] A_LAST = AW'(QUALIFY_ACKS - 1);

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        QUALIFY = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] per;
    logic [PW-1:0] per_nx;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_nx;
    logic [AW-1:0] acks;
    logic [AW-1:0] acks_nx;
    logic          retry;
    logic          retry_nx;
    logic          fail;
    logic          enter_lock;
    logic          locked_nx;
    logic          rst_nx;
    logic [3:0]    rate_nx;

    function automatic logic [3:0] rate_of(input logic [PW-1:0] p);
        if (p <= T_192)     return 4'b1000;
        else if (p <= T_96) return 4'b0100;
        else if (p <= T_48) return 4'b0010;
        else                return 4'b0001;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SETTLE;
            per      <= P_MIN;
            tmr      <= '0;
            acks     <= '0;
            retry    <= 1'b0;
            locked_o <= 1'b0;
            rst_o    <= 1'b0;
            rate_o   <= 4'b0000;
        end else begin
            state    <= state_nx;
            per      <= per_nx;
            tmr      <= tmr_nx;
            acks     <= acks_nx;
            retry    <= retry_nx;
            locked_o <= locked_nx;
            rst_o    <= rst_nx;
            rate_o   <= rate_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        tmr_nx     = tmr;
        acks_nx    = acks;
        retry_nx   = retry;
        fail       = 1'b0;
        enter_lock = 1'b0;
        unique case (state)
            SETTLE: begin
                if (dai_locked_i) begin
                    state_nx = QUALIFY;
                    tmr_nx   = '0;
                    acks_nx  = '0;
                end else if (tmr == T_LAST) begin
                    fail = 1'b1;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            QUALIFY: begin
                // Lock loss beats a coincident ack.
                if (!dai_locked_i) begin
                    fail = 1'b1;
                end else if (dai_ack_i) begin
                    tmr_nx = '0;
                    if (acks == A_LAST) enter_lock = 1'b1;
                    else                acks_nx = acks + 1'b1;
                end else if (tmr == T_LAST) begin
                    fail = 1'b1;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            LOCKED: begin
                if (!dai_locked_i) begin
                    state_nx = SETTLE;
                    tmr_nx   = '0;
                    retry_nx = 1'b1;
                end
            end
            default: begin
                state_nx = SETTLE;
                tmr_nx   = '0;
            end
        endcase
        if (fail) begin
            state_nx = SETTLE;
            tmr_nx   = '0;
            retry_nx = 1'b0;
        end
        if (enter_lock) begin
            state_nx = LOCKED;
            retry_nx = 1'b0;
        end
    end

    always_comb begin
        per_nx = per;
        if (fail && !hold_i)
            per_nx = (per == P_MAX) ? P_MIN : per + 1'b1;
    end

    always_comb begin
        locked_nx  = (state_nx == LOCKED);
        rst_nx     = enter_lock;
        rate_nx    = 4'b0000;
        if (enter_lock)
            rate_nx = rate_of(per);
        else if (state_nx == LOCKED)
            rate_nx = rate_o;
        scanning_o = (state != LOCKED);
    end

    assign clk_per_halfbit_o = per;

endmodule
